// File: rtl/case_1_sdiv_pkg.sv
// Shared types and default widths for the sequential signed divider.
// Optional feature macro used by the top: CASE_1_SDIV_DBZ_FLAG_EN.
package case_1_sdiv_pkg;

    localparam int DIVIDEND_WIDTH = 14;
    localparam int DIVISOR_WIDTH  = 12;
    localparam int PREM_WIDTH     = DIVISOR_WIDTH + 1;
    localparam int CNT_WIDTH      = $clog2(DIVIDEND_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/case_1_sdiv_step.sv
// One radix-2 restoring division iteration on magnitudes (purely combinational).
module case_1_sdiv_step #(
    parameter int DIVISOR_WIDTH = case_1_sdiv_pkg::DIVISOR_WIDTH
) (
    input  logic [DIVISOR_WIDTH:0]   prem,
    input  logic                     dbit,
    input  logic [DIVISOR_WIDTH-1:0] dvsr,
    output logic [DIVISOR_WIDTH:0]   prem_next,
    output logic                     qbit
);

    logic [DIVISOR_WIDTH:0] shifted;
    logic [DIVISOR_WIDTH:0] dvsr_ext;

    // Shift in the next dividend bit, then subtract the divisor if it fits.
    // A set top bit in the incoming partial remainder means the shifted value
    // overflowed the register and is certainly >= divisor; the modular
    // subtraction still yields the exact result because it is < 2*divisor.
    always_comb begin
        shifted   = {prem[DIVISOR_WIDTH-1:0], dbit};
        dvsr_ext  = {1'b0, dvsr};
        qbit      = prem[DIVISOR_WIDTH] | (shifted >= dvsr_ext);
        prem_next = qbit ? (shifted - dvsr_ext) : shifted;
    end

endmodule

// File: rtl/case_1_sdiv_seq_14s_12s.sv
// Multi-cycle signed divider: magnitudes are divided by a restoring loop,
// signs are restored in a final fix-up cycle. Valid/ready on both sides.
// Optional macro CASE_1_SDIV_DBZ_FLAG_EN adds a registered divide-by-zero flag.
module case_1_sdiv_seq_14s_12s #(
    parameter int DIVIDEND_WIDTH = case_1_sdiv_pkg::DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = case_1_sdiv_pkg::DIVISOR_WIDTH,
    parameter int ID             = 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder
`ifdef CASE_1_SDIV_DBZ_FLAG_EN
    ,
    output logic                      dbz
`endif
);

    import case_1_sdiv_pkg::*;

    localparam int PREM_W = DIVISOR_WIDTH + 1;
    localparam int CNT_W  = $clog2(DIVIDEND_WIDTH);

    state_t                    state;
    state_t                    state_nxt;

    // Dividend magnitude shifts out MSB-first while quotient bits shift in.
    logic [DIVIDEND_WIDTH-1:0] dq;
    logic [DIVISOR_WIDTH-1:0]  dvsr_mag;
    logic [PREM_W-1:0]         prem;
    logic [CNT_W-1:0]          cnt;
    logic                      neg_quo;
    logic                      neg_rem;
    logic                      dvsr_zero;

    logic [PREM_W-1:0]         step_prem;
    logic                      step_qbit;

    case_1_sdiv_step #(
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_step (
        .prem      (prem),
        .dbit      (dq[DIVIDEND_WIDTH-1]),
        .dvsr      (dvsr_mag),
        .prem_next (step_prem),
        .qbit      (step_qbit)
    );

    assign in_ready = (state == IDLE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)       state_nxt = CALC;
            CALC: if (cnt == '0)      state_nxt = FIX;
            FIX:                      state_nxt = DONE;
            DONE: if (out_ready)      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, sign fix-up and output registers.
    // A zero divisor is folded into capture and iteration (partial remainder
    // pinned at 0, quotient sign left positive) so the fix-up stays generic.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dq        <= '0;
            dvsr_mag  <= '0;
            prem      <= '0;
            cnt       <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            dvsr_zero <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            out_valid <= 1'b0;
`ifdef CASE_1_SDIV_DBZ_FLAG_EN
            dbz       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dq        <= dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
                        dvsr_mag  <= divisor[DIVISOR_WIDTH-1] ? -divisor : divisor;
                        neg_quo   <= (dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1])
                                     & (divisor != '0);
                        neg_rem   <= dividend[DIVIDEND_WIDTH-1];
                        dvsr_zero <= (divisor == '0);
                        prem      <= '0;
                        cnt       <= CNT_W'(DIVIDEND_WIDTH - 1);
                    end
                end
                CALC: begin
                    dq   <= {dq[DIVIDEND_WIDTH-2:0], step_qbit};
                    prem <= dvsr_zero ? '0 : step_prem;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quotient  <= neg_quo ? -dq : dq;
                    remainder <= neg_rem ? -prem[DIVISOR_WIDTH-1:0] : prem[DIVISOR_WIDTH-1:0];
                    out_valid <= 1'b1;
`ifdef CASE_1_SDIV_DBZ_FLAG_EN
                    dbz       <= dvsr_zero;
`endif
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_case_1_sdiv_seq_14s_12s.sv
// Scoreboard bench for the sequential signed divider.
module tb_case_1_sdiv_seq_14s_12s;

    typedef struct packed {
        logic [13:0] q;
        logic [11:0] r;
        logic        z;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] dividend = '0;
    logic [11:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [13:0] quotient;
    logic [11:0] remainder;
`ifdef CASE_1_SDIV_DBZ_FLAG_EN
    logic        dbz;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t exp_q[$];

    case_1_sdiv_seq_14s_12s dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef CASE_1_SDIV_DBZ_FLAG_EN
        ,
        .dbz       (dbz)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   q;
        int   r;
        if (b == 0) begin
            q = -1;
            r = 0;
        end else begin
            q = a / b;
            r = a % b;
        end
        e.q = q[13:0];
        e.r = r[11:0];
        e.z = (b == 0);
        return e;
    endfunction

    // Drive one operand pair when the divider is ready; push its expected result.
    task automatic send(input int a, input int b);
        int guard = 0;
        @(negedge ap_clk);
        while (!in_ready && guard < 100) begin
            @(negedge ap_clk);
            guard++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        dividend = a[13:0];
        divisor  = b[11:0];
        in_valid = 1'b1;
        acc_cyc  = cyc;
        exp_q.push_back(model(a, b));
        @(posedge ap_clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid and check the latency from acceptance.
    task automatic wait_valid(input string tag, input int exp_lat);
        do @(negedge ap_clk); while (!out_valid && (cyc - acc_cyc) < 60);
        check(tag, cyc - acc_cyc, exp_lat);
    endtask

    // Output monitor: compare each handshaken result against the scoreboard.
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", {18'd0, quotient}, {18'd0, e.q});
                check("remainder", {20'd0, remainder}, {20'd0, e.r});
`ifdef CASE_1_SDIV_DBZ_FLAG_EN
                check("dbz", {31'd0, dbz}, {31'd0, e.z});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a_list [9] = '{-100, 100, -100, -8192, 8191, 555, 555, -555, 37};
        int b_list [9] = '{7, -7, -7, -1, -2048, 0, 5, 0, -5};
        int prev_acc;

        // Reset state.
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {18'd0, quotient}, 32'd0);
        check("rst_remainder", {20'd0, remainder}, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Basic case with latency check.
        send(100, 7);
        wait_valid("latency_100_7", 16);

        // Sign combinations and boundaries, issued back to back.
        prev_acc = -1;
        for (int i = 0; i < 9; i++) begin
            send(a_list[i], b_list[i]);
            if (prev_acc >= 0) check("throughput", acc_cyc - prev_acc, 17);
            prev_acc = acc_cyc;
        end
        wait_valid("latency_last", 16);

        // Back-pressure: hold out_ready low for 10 cycles after out_valid.
        @(posedge ap_clk);
        #1 out_ready = 1'b0;
        send(37, 5);
        wait_valid("latency_hold", 16);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_quotient", {18'd0, quotient}, 32'd7);
            check("hold_remainder", {20'd0, remainder}, 32'd2);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge ap_clk);
        end
        @(posedge ap_clk);
        #1 out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        prev_acc = cyc;
        send(-37, 5);
        check("back_to_back_accept", acc_cyc, prev_acc);
        wait_valid("latency_b2b", 16);

        // Reset in the middle of a division.
        send(1000, 3);
        repeat (4) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_quotient", {18'd0, quotient}, 32'd0);
        check("abort_remainder", {20'd0, remainder}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (20) @(negedge ap_clk);
        check("abort_no_result", {31'd0, out_valid}, 32'd0);

        send(9, 4);
        wait_valid("latency_after_reset", 16);
        repeat (3) @(negedge ap_clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/case_1_sdiv_seq_14s_12s.md
Name: case_1_sdiv_seq_14s_12s

Overview:
Multi-cycle signed integer divider. It is the inverse operator of the combinational signed multiplier in the same datapath: it recovers a quotient and remainder from a product-width operand.
- Uses a radix-2 restoring algorithm on magnitudes, then applies sign correction.
- Has valid/ready handshakes on both the input and output sides.
- Instantiated by the synthesised top wherever a non-constant signed division or modulo appears.

Parameters:
- DIVIDEND_WIDTH, 14: dividend and quotient width, two's complement.
- DIVISOR_WIDTH, 12: divisor and remainder width, two's complement.
- ID, 1: instance tag. No functional effect.

Ports:
- ap_clk, input, 1: clock. All state updates on the rising edge.
- ap_rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: dividend and divisor are valid.
- in_ready, output, 1: divider can accept a new operand pair.
- dividend, input, DIVIDEND_WIDTH: signed dividend.
- divisor, input, DIVISOR_WIDTH: signed divisor.
- out_valid, output, 1: quotient and remainder are valid.
- out_ready, input, 1: consumer accepts the result.
- quotient, output, DIVIDEND_WIDTH: signed quotient, truncated toward zero.
- remainder, output, DIVISOR_WIDTH: signed remainder; its sign follows the dividend.

Behaviour:
- Reset (async assert, deassert sampled on ap_clk):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, iteration counter = 0.
- Reset asserted mid-operation aborts the division immediately. No result is produced.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture:
    - |dividend| into an unsigned DIVIDEND_WIDTH register (−2^(W−1) maps to 2^(W−1)).
    - |divisor| into DIVISOR_WIDTH bits.
    - sign bits of both operands.
    - Clear the partial remainder (DIVISOR_WIDTH+1 bits). Set counter = DIVIDEND_WIDTH−1. Go to CALC.
  - CALC: one quotient bit per cycle, MSB first:
    - Shift the partial remainder left, bringing in the next dividend bit.
    - If the shifted value ≥ |divisor|, subtract |divisor| and set the quotient bit to 1.
    - At counter == 0, go to FIX; otherwise decrement the counter.
  - FIX: quotient is negated if the sign bits differ. Remainder is negated if the dividend is negative. Register both outputs, set out_valid = 1, go to DONE.
  - DONE: hold outputs stable while out_ready = 0. On out_ready, clear out_valid and go to IDLE.
- in_ready is 0 in CALC, FIX and DONE. A new operand pair is never accepted in the same cycle as the output handshake.
- Latency: operands accepted in cycle 0 produce out_valid = 1 in cycle DIVIDEND_WIDTH+2 (cycle 16 at defaults).
- Throughput: one division per DIVIDEND_WIDTH+3 cycles when out_ready is held at 1.
- Divide by zero: quotient = all ones, remainder = 0. Timing is identical, with no early exit.
- Overflow, −2^(DIVIDEND_WIDTH−1) / −1: quotient wraps to −2^(DIVIDEND_WIDTH−1), remainder = 0. No flag is raised.
- Divisor −2^(DIVISOR_WIDTH−1): its magnitude 2^(DIVISOR_WIDTH−1) is held exactly by the unsigned divisor register.
- Quotient and remainder change only on the FIX→DONE edge. They hold their values through IDLE until the next FIX.

Optional Feature:
- Macro: CASE_1_SDIV_DBZ_FLAG_EN.
- When defined: an extra output port dbz (1 bit) is added.
  - Registered together with quotient; valid while out_valid = 1.
  - dbz = 1 if the captured divisor was 0, else dbz = 0. Reset value 0.
- When not defined: no dbz port, and the zero-divisor check is not part of the output path. The divide-by-zero result values stay as specified above.

Decomposition:
- Package case_1_sdiv_pkg:
  - state enum {IDLE, CALC, FIX, DONE}.
  - localparam widths: DIVIDEND_WIDTH, DIVISOR_WIDTH, PREM_WIDTH = DIVISOR_WIDTH+1, CNT_WIDTH = $clog2(DIVIDEND_WIDTH).
- Sub-module case_1_sdiv_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: next partial remainder, quotient bit.
- FSM, counter and sign fix stay in the top module.

Test Plan:
- 100 / 7, out_ready = 1 → quotient 14, remainder 2, out_valid in cycle 16 after acceptance.
- −100 / 7 → quotient −14, remainder −2. 100 / −7 → quotient −14, remainder 2. −100 / −7 → quotient 14, remainder −2.
- −8192 / −1 → quotient −8192 (0x2000), remainder 0. 8191 / −2048 → quotient −3, remainder 2047.
- 555 / 0 → quotient 0x3FFF, remainder 0. With the macro defined, dbz = 1; for 555 / 5, dbz = 0.
- 37 / 5 with out_ready held 0 for 10 cycles after out_valid:
  - outputs stay 7 / 2 and in_ready stays 0 throughout.
  - out_ready = 1 for one cycle → out_valid drops and in_ready rises the next cycle.
  - A back-to-back second pair is accepted and is correct.
- Start 1000 / 3; assert ap_rst_n = 0 in cycle 5 → in the same cycle out_valid = 0, in_ready = 1, quotient = 0, remainder = 0. After release, 9 / 4 → quotient 2, remainder 1.
